dpram_pipe_buf: RTL and testbench

- Parametrised successor to the team's simple dual-port buffer primitive: one write port, one read port, single clock.
- Adds per-byte write enables, a configurable read pipeline with a valid flag, a read-pipeline stall, out-of-range address protection with a sticky error flag, and optional same-cycle write-to-read forwarding.
- Instantiated for IFM, row, filter and affine buffers wherever consumers need a valid-qualified, stallable read stream.

---
 rtl/dpram_pipe_buf.sv | 112 +++++++++++
 tb/tb_dpram_pipe_buf.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dpram_pipe_buf.sv
// dpram_pipe_buf: single-clock simple dual-port buffer. It has one write port with
// per-byte enables and one read port with an N_DELAY-stage read pipeline that can be
// stalled. Reads outside DEPTH return zero, and any out-of-range access sets a sticky
// error flag.
// Optional build macro: DPRAM_RAW_FWD_EN. When it is defined, a read of the address
// being written in the same cycle returns the merged new word instead of the old
// contents.
module dpram_pipe_buf #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 10,
    parameter int unsigned DEPTH   = 1 << AW,
    parameter int unsigned N_DELAY = 2,
    parameter int unsigned NB      = DW / 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ena,
    input  logic [NB-1:0] wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dia,
    input  logic          enb,
    input  logic [AW-1:0] addrb,
    input  logic          rd_hold,
    output logic [DW-1:0] dob,
    output logic          dob_vld,
    output logic          oob_err
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]      mem [DEPTH];
    logic               in_range_a;
    logic               in_range_b;
    logic               wr_fire;
    logic               wr_oob;
    logic               rd_acc;
    logic               rd_oob;
    logic [DW-1:0]      rd_word;
    logic [DW-1:0]      pipe_d [N_DELAY];
    logic [N_DELAY-1:0] pipe_v;
    logic               oob_q;

    // Address qualification and port handshakes
    assign in_range_a = (32'(addra) < DEPTH);
    assign in_range_b = (32'(addrb) < DEPTH);
    assign wr_fire    = ena && in_range_a && (wea != '0);
    assign wr_oob     = ena && !in_range_a && (wea != '0);
    assign rd_acc     = enb && !rd_hold;
    assign rd_oob     = rd_acc && !in_range_b;

    // Memory array write with byte-lane enables; the array is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) begin
                    mem[IW'(addra)][8*i +: 8] <= dia[8*i +: 8];
                end
            end
        end
    end

    // Word presented to stage 0: zero when out of range, old contents otherwise
    always_comb begin
        rd_word = '0;
        if (in_range_b) begin
            rd_word = mem[IW'(addrb)];
`ifdef DPRAM_RAW_FWD_EN
            // Same-cycle write to the read address: take the new bytes on enabled lanes
            if (wr_fire && (addra == addrb)) begin
                for (int i = 0; i < NB; i++) begin
                    if (wea[i]) begin
                        rd_word[8*i +: 8] = dia[8*i +: 8];
                    end
                end
            end
`endif
        end
    end

    // Read pipeline: stage 0 is the RAM read register, and rd_hold freezes every stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_v <= '0;
            for (int i = 0; i < int'(N_DELAY); i++) begin
                pipe_d[i] <= '0;
            end
        end else if (!rd_hold) begin
            pipe_v[0] <= enb;
            if (enb) begin
                pipe_d[0] <= rd_word;
            end
            for (int i = 1; i < int'(N_DELAY); i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    // Sticky out-of-range flag, cleared only by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oob_q <= 1'b0;
        end else if (wr_oob || rd_oob) begin
            oob_q <= 1'b1;
        end
    end

    assign dob     = pipe_d[N_DELAY-1];
    assign dob_vld = pipe_v[N_DELAY-1];
    assign oob_err = oob_q;

endmodule

// File: tb/tb_dpram_pipe_buf.sv
// Directed testbench for dpram_pipe_buf (DEPTH=1000, N_DELAY=2).
module tb_dpram_pipe_buf;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned NB = DW / 8;

    logic          clk;
    logic          rstn;
    logic          ena;
    logic [NB-1:0] wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dia;
    logic          enb;
    logic [AW-1:0] addrb;
    logic          rd_hold;
    logic [DW-1:0] dob;
    logic          dob_vld;
    logic          oob_err;

    int vectors;
    int miscompares;

    dpram_pipe_buf #(
        .DW(DW), .AW(AW), .DEPTH(1000), .N_DELAY(2)
    ) dut (
        .clk(clk), .rstn(rstn), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .enb(enb), .addrb(addrb), .rd_hold(rd_hold),
        .dob(dob), .dob_vld(dob_vld), .oob_err(oob_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        ena = 1'b1; addra = a; dia = d; wea = be;
        tick();
        ena = 1'b0; wea = '0;
    endtask

    // Single read of address a: accept on one edge, data valid after the next edge
    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
        enb = 1'b1; addrb = a;
        tick();
        enb = 1'b0;
        tick();
        d = dob; v = dob_vld;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        vectors++; if (dob !== '0)      begin miscompares++; $display("FAIL reset_dob got %h want 0", dob); end
        vectors++; if (dob_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld got %b want 0", dob_vld); end
        vectors++; if (oob_err !== 1'b0) begin miscompares++; $display("FAIL reset_oob got %b want 0", oob_err); end
        tick();
        #2 rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_write(10'd5, 32'hDEADBEEF, 4'hF);
        enb = 1'b1; addrb = 10'd5;
        tick();
        enb = 1'b0;
        vectors++; if (dob_vld !== 1'b0) begin miscompares++; $display("FAIL basic_pre_vld got %b want 0", dob_vld); end
        tick();
        vectors++; if (dob_vld !== 1'b1) begin miscompares++; $display("FAIL basic_vld got %b want 1", dob_vld); end
        vectors++; if (dob !== 32'hDEADBEEF) begin miscompares++; $display("FAIL basic_dob got %h want deadbeef", dob); end
        tick();
        vectors++; if (dob_vld !== 1'b0) begin miscompares++; $display("FAIL basic_post_vld got %b want 0", dob_vld); end
    endtask

    task automatic test_byte_en();
        logic [DW-1:0] d;
        logic v;
        do_write(10'd5, 32'h11223344, 4'b0101);
        do_read(10'd5, d, v);
        vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL bytes_vld got %b want 1", v); end
        vectors++; if (d !== 32'hDE22BE44) begin miscompares++; $display("FAIL bytes_dob got %h want de22be44", d); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) do_write(AW'(i), 32'hA0 + DW'(i), 4'hF);
        do_write(10'd9, 32'h000000B9, 4'hF);
        tick();
        enb = 1'b1; addrb = 10'd0;
        tick();
        addrb = 10'd1;
        tick();
        vectors++; if (dob !== 32'hA0 || dob_vld !== 1'b1) begin miscompares++; $display("FAIL stall_first got %h/%b want a0/1", dob, dob_vld); end
        // Hold three cycles while presenting a read that must be dropped
        rd_hold = 1'b1; addrb = 10'd9;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (dob !== 32'hA0 || dob_vld !== 1'b1) begin miscompares++; $display("FAIL stall_hold%0d got %h/%b want a0/1", c, dob, dob_vld); end
        end
        rd_hold = 1'b0; addrb = 10'd2;
        tick();
        vectors++; if (dob !== 32'hA1 || dob_vld !== 1'b1) begin miscompares++; $display("FAIL stall_a1 got %h/%b want a1/1", dob, dob_vld); end
        addrb = 10'd3;
        tick();
        vectors++; if (dob !== 32'hA2 || dob_vld !== 1'b1) begin miscompares++; $display("FAIL stall_a2 got %h/%b want a2/1", dob, dob_vld); end
        enb = 1'b0;
        tick();
        vectors++; if (dob !== 32'hA3 || dob_vld !== 1'b1) begin miscompares++; $display("FAIL stall_a3 got %h/%b want a3/1", dob, dob_vld); end
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++; if (dob_vld !== 1'b0) begin miscompares++; $display("FAIL stall_drain%0d got vld %b dob %h want 0", c, dob_vld, dob); end
        end
    endtask

    task automatic test_oob();
        logic [DW-1:0] d;
        logic v;
        do_write(10'd999, 32'h5A5A5A5A, 4'hF);
        vectors++; if (oob_err !== 1'b0) begin miscompares++; $display("FAIL oob_clear got %b want 0", oob_err); end
        do_write(10'd1000, 32'h12345678, 4'hF);
        vectors++; if (oob_err !== 1'b1) begin miscompares++; $display("FAIL oob_wr_flag got %b want 1", oob_err); end
        do_read(10'd1023, d, v);
        vectors++; if (d !== '0 || v !== 1'b1) begin miscompares++; $display("FAIL oob_rd got %h/%b want 0/1", d, v); end
        do_read(10'd999, d, v);
        vectors++; if (d !== 32'h5A5A5A5A || v !== 1'b1) begin miscompares++; $display("FAIL oob_999 got %h/%b want 5a5a5a5a/1", d, v); end
        tick();
        vectors++; if (oob_err !== 1'b1) begin miscompares++; $display("FAIL oob_sticky got %b want 1", oob_err); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] d;
        logic [DW-1:0] exp_d;
        logic v;
`ifdef DPRAM_RAW_FWD_EN
        exp_d = 32'hFFFFFFFF;
`else
        exp_d = 32'h00000000;
`endif
        do_write(10'd7, 32'h00000000, 4'hF);
        ena = 1'b1; wea = 4'hF; addra = 10'd7; dia = 32'hFFFFFFFF;
        enb = 1'b1; addrb = 10'd7;
        tick();
        ena = 1'b0; wea = '0; enb = 1'b0;
        tick();
        vectors++; if (dob !== exp_d || dob_vld !== 1'b1) begin miscompares++; $display("FAIL collide_rd got %h/%b want %h/1", dob, dob_vld, exp_d); end
        do_read(10'd7, d, v);
        vectors++; if (d !== 32'hFFFFFFFF || v !== 1'b1) begin miscompares++; $display("FAIL collide_follow got %h/%b want ffffffff/1", d, v); end
    endtask

    task automatic test_reset_inflight();
        logic [DW-1:0] d;
        logic v;
        enb = 1'b1; addrb = 10'd5;
        tick();
        addrb = 10'd0;
        tick();
        enb = 1'b0;
        rstn = 1'b0;
        #1;
        vectors++; if (dob !== '0 || dob_vld !== 1'b0) begin miscompares++; $display("FAIL rst_async got %h/%b want 0/0", dob, dob_vld); end
        vectors++; if (oob_err !== 1'b0) begin miscompares++; $display("FAIL rst_oob got %b want 0", oob_err); end
        #2 rstn = 1'b1;
        do_read(10'd5, d, v);
        vectors++; if (d !== 32'hDE22BE44 || v !== 1'b1) begin miscompares++; $display("FAIL rst_keep5 got %h/%b want de22be44/1", d, v); end
        do_read(10'd1, d, v);
        vectors++; if (d !== 32'hA1 || v !== 1'b1) begin miscompares++; $display("FAIL rst_keep1 got %h/%b want a1/1", d, v); end
        do_read(10'd7, d, v);
        vectors++; if (d !== 32'hFFFFFFFF || v !== 1'b1) begin miscompares++; $display("FAIL rst_keep7 got %h/%b want ffffffff/1", d, v); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vectors = 0; miscompares = 0;
        rstn = 1'b1; ena = 1'b0; wea = '0; addra = '0; dia = '0;
        enb = 1'b0; addrb = '0; rd_hold = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_byte_en();
        test_stall();
        test_oob();
        test_collision();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
